// File: rtl/am2911_next_addr_ctrl.sv
// -----------------------------------------------------------------------------
// am2911_next_addr_ctrl
//
// Purpose:
//    Next-address controller for a cascade of Am2911 microprogram sequencer
//    slices. It decodes the 4-bit next-address opcode and a polarity-adjusted
//    test condition into the shared slice control lines (S0/S1, ZERO, Cn,
//    RE, FE, PUP). It also owns the loop counter, the RUN/HALT sequencing and
//    a model of the slices' stack depth, including sticky overflow and
//    underflow flags.
//
// Configuration macro:
//    AM2911_STACK_GUARD_EN - when defined, an overflowing push or an
//    underflowing pop is suppressed (FE held high). The branch part of the
//    opcode still executes and the flags are still set. When undefined, the
//    stack operation reaches the slices unchanged and only the flags record
//    the event.
//
// Ports:
//    clock       in   system clock, rising edge
//    reset_n     in   synchronous active-low reset
//    op          in   [3:0] next-address opcode
//    cond        in   raw test condition
//    cond_pol    in   1: test passes on cond=1, 0: test passes on cond=0
//    cnt_in      in   [CNT_W-1:0] loop count loaded by LDCT
//    hold        in   freeze the sequencer this cycle (ignored in HALT)
//    start       in   leave HALT state
//    clr_flags   in   clear stack_ovf / stack_unf
//    seq_s0/s1   out  slice source select
//    seq_zero_n  out  slice ZERO (0 forces Y=0)
//    seq_cin     out  slice Cn (1 = increment)
//    seq_re_n    out  slice RE (0 loads AR from D)
//    seq_fe_n    out  slice FE (0 enables stack op)
//    seq_pup     out  slice PUP (1 push, 0 pop)
//    halted      out  HALT state indicator
//    cnt_zero    out  loop counter is zero
//    depth       out  [2:0] tracked stack depth, 0..STACK_DEPTH
//    stack_ovf   out  sticky: push attempted at full depth
//    stack_unf   out  sticky: pop attempted at depth 0
// -----------------------------------------------------------------------------
module am2911_next_addr_ctrl #(
   parameter int CNT_W       = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [3:0]       op,
   input  logic             cond,
   input  logic             cond_pol,
   input  logic [CNT_W-1:0] cnt_in,
   input  logic             hold,
   input  logic             start,
   input  logic             clr_flags,
   output logic             seq_s0,
   output logic             seq_s1,
   output logic             seq_zero_n,
   output logic             seq_cin,
   output logic             seq_re_n,
   output logic             seq_fe_n,
   output logic             seq_pup,
   output logic             halted,
   output logic             cnt_zero,
   output logic [2:0]       depth,
   output logic             stack_ovf,
   output logic             stack_unf
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fsm_t;

   localparam logic [3:0] OP_CONT = 4'h0;
   localparam logic [3:0] OP_JMP  = 4'h1;
   localparam logic [3:0] OP_CJMP = 4'h2;
   localparam logic [3:0] OP_JSR  = 4'h3;
   localparam logic [3:0] OP_CJSR = 4'h4;
   localparam logic [3:0] OP_RTS  = 4'h5;
   localparam logic [3:0] OP_CRTS = 4'h6;
   localparam logic [3:0] OP_LDAR = 4'h7;
   localparam logic [3:0] OP_JAR  = 4'h8;
   localparam logic [3:0] OP_LDCT = 4'h9;
   localparam logic [3:0] OP_RPCT = 4'hA;
   localparam logic [3:0] OP_LOOP = 4'hB;
   localparam logic [3:0] OP_PUSH = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hD;
   localparam logic [3:0] OP_ZERO = 4'hE;

   localparam logic [2:0]       DEPTH_MAX = 3'(STACK_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // Registered state
   fsm_t             fsm_q, fsm_d;
   logic [CNT_W-1:0] counter_q, counter_d;
   logic [2:0]       depth_q, depth_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   // Combinational control lines
   logic [1:0] sel_s;
   logic       zero_n_s;
   logic       cin_s;
   logic       re_n_s;
   logic       fe_n_s;
   logic       pup_s;
   logic       test_s;
   logic       push_s;
   logic       pop_s;
   logic       ovf_evt_s;
   logic       unf_evt_s;

   assign test_s = ~(cond ^ cond_pol);

   // Opcode decode, stall/reset override and next-state computation
   always_comb begin
      sel_s     = 2'b00;
      zero_n_s  = 1'b1;
      cin_s     = 1'b1;
      re_n_s    = 1'b1;
      fe_n_s    = 1'b1;
      pup_s     = 1'b0;
      push_s    = 1'b0;
      pop_s     = 1'b0;
      ovf_evt_s = 1'b0;
      unf_evt_s = 1'b0;
      fsm_d     = fsm_q;
      counter_d = counter_q;
      depth_d   = depth_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;

      if (!reset_n) begin
         // Force Y=0 with no increment so the slice PC clears on this edge.
         zero_n_s = 1'b0;
         cin_s    = 1'b0;
      end else if ((fsm_q == ST_HALT) || hold) begin
         // Re-select PC without increment: the slice PC holds.
         cin_s = 1'b0;
         if ((fsm_q == ST_HALT) && start) begin
            fsm_d = ST_RUN;
         end else begin
            fsm_d = fsm_q;
         end
      end else begin
         case (op)
            OP_CONT: begin
               sel_s = 2'b00;
            end
            OP_JMP: begin
               sel_s = 2'b11;
            end
            OP_CJMP: begin
               if (test_s) begin
                  sel_s = 2'b11;
               end else begin
                  sel_s = 2'b00;
               end
            end
            OP_JSR: begin
               sel_s  = 2'b11;
               push_s = 1'b1;
            end
            OP_CJSR: begin
               if (test_s) begin
                  sel_s  = 2'b11;
                  push_s = 1'b1;
               end else begin
                  sel_s = 2'b00;
               end
            end
            OP_RTS: begin
               sel_s = 2'b10;
               pop_s = 1'b1;
            end
            OP_CRTS: begin
               if (test_s) begin
                  sel_s = 2'b10;
                  pop_s = 1'b1;
               end else begin
                  sel_s = 2'b00;
               end
            end
            OP_LDAR: begin
               re_n_s = 1'b0;
            end
            OP_JAR: begin
               sel_s = 2'b01;
            end
            OP_LDCT: begin
               counter_d = cnt_in;
            end
            OP_RPCT: begin
               if (counter_q != CNT_ZERO) begin
                  sel_s     = 2'b01;
                  counter_d = counter_q - CNT_ONE;
               end else begin
                  sel_s = 2'b00;
               end
            end
            OP_LOOP: begin
               // Condition false: branch back to stack top, keep the entry.
               // Condition true: fall through and discard the loop entry.
               if (test_s) begin
                  sel_s = 2'b00;
                  pop_s = 1'b1;
               end else begin
                  sel_s = 2'b10;
               end
            end
            OP_PUSH: begin
               push_s = 1'b1;
            end
            OP_HALT: begin
               fsm_d = ST_HALT;
            end
            OP_ZERO: begin
               zero_n_s = 1'b0;
            end
            default: begin
               sel_s = 2'b00;
            end
         endcase

         ovf_evt_s = push_s && (depth_q == DEPTH_MAX);
         unf_evt_s = pop_s && (depth_q == 3'd0);

         if (push_s) begin
            fe_n_s = 1'b0;
            pup_s  = 1'b1;
         end else if (pop_s) begin
            fe_n_s = 1'b0;
            pup_s  = 1'b0;
         end else begin
            fe_n_s = 1'b1;
         end

`ifdef AM2911_STACK_GUARD_EN
         if (ovf_evt_s || unf_evt_s) begin
            fe_n_s = 1'b1;
         end else begin
            fe_n_s = fe_n_s;
         end
`endif

         // Depth saturates at both ends whether or not the op is suppressed.
         if (push_s && !ovf_evt_s) begin
            depth_d = depth_q + 3'd1;
         end else if (pop_s && !unf_evt_s) begin
            depth_d = depth_q - 3'd1;
         end else begin
            depth_d = depth_q;
         end

         // A new violation beats a simultaneous clear.
         ovf_d = (ovf_q & ~clr_flags) | ovf_evt_s;
         unf_d = (unf_q & ~clr_flags) | unf_evt_s;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         fsm_q     <= ST_RUN;
         counter_q <= CNT_ZERO;
         depth_q   <= 3'd0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         fsm_q     <= fsm_d;
         counter_q <= counter_d;
         depth_q   <= depth_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   assign seq_s0     = sel_s[0];
   assign seq_s1     = sel_s[1];
   assign seq_zero_n = zero_n_s;
   assign seq_cin    = cin_s;
   assign seq_re_n   = re_n_s;
   assign seq_fe_n   = fe_n_s;
   assign seq_pup    = pup_s;
   assign halted     = reset_n & (fsm_q == ST_HALT);
   assign cnt_zero   = ~reset_n | (counter_q == CNT_ZERO);
   assign depth      = depth_q;
   assign stack_ovf  = ovf_q;
   assign stack_unf  = unf_q;

endmodule

// File: tb/tb_am2911_next_addr_ctrl.sv
// Directed bench for am2911_next_addr_ctrl. Control lines are compared as a
// 7-bit vector {S1,S0,ZERO_n,Cn,RE_n,FE_n,PUP}.
module tb_am2911_next_addr_ctrl;

   logic       clock;
   logic       reset_n;
   logic [3:0] op;
   logic       cond;
   logic       cond_pol;
   logic [7:0] cnt_in;
   logic       hold;
   logic       start;
   logic       clr_flags;
   logic       seq_s0, seq_s1, seq_zero_n, seq_cin, seq_re_n, seq_fe_n, seq_pup;
   logic       halted, cnt_zero, stack_ovf, stack_unf;
   logic [2:0] depth;
   logic [6:0] ctrl;

   int n_checks;
   int n_fail;

   // Expected vectors
   localparam logic [6:0] V_RESET = 7'b0000110;
   localparam logic [6:0] V_CONT  = 7'b0011110;
   localparam logic [6:0] V_STALL = 7'b0010110;
   localparam logic [6:0] V_JMP   = 7'b1111110;
   localparam logic [6:0] V_JSR   = 7'b1111101;
   localparam logic [6:0] V_RTS   = 7'b1011100;
   localparam logic [6:0] V_JAR   = 7'b0111110;
   localparam logic [6:0] V_LOOPB = 7'b1011110;
   localparam logic [6:0] V_POP   = 7'b0011100;
   localparam logic [6:0] V_PUSH  = 7'b0011101;
   localparam logic [6:0] V_LDAR  = 7'b0011010;
   localparam logic [6:0] V_ZERO  = 7'b0001110;
`ifdef AM2911_STACK_GUARD_EN
   localparam logic [6:0] V_RTS_UNF  = 7'b1011110;
   localparam logic [6:0] V_PUSH_OVF = 7'b0011111;
`else
   localparam logic [6:0] V_RTS_UNF  = 7'b1011100;
   localparam logic [6:0] V_PUSH_OVF = 7'b0011101;
`endif

   assign ctrl = {seq_s1, seq_s0, seq_zero_n, seq_cin, seq_re_n, seq_fe_n, seq_pup};

   am2911_next_addr_ctrl #(.CNT_W(8), .STACK_DEPTH(4)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .op         (op),
      .cond       (cond),
      .cond_pol   (cond_pol),
      .cnt_in     (cnt_in),
      .hold       (hold),
      .start      (start),
      .clr_flags  (clr_flags),
      .seq_s0     (seq_s0),
      .seq_s1     (seq_s1),
      .seq_zero_n (seq_zero_n),
      .seq_cin    (seq_cin),
      .seq_re_n   (seq_re_n),
      .seq_fe_n   (seq_fe_n),
      .seq_pup    (seq_pup),
      .halted     (halted),
      .cnt_zero   (cnt_zero),
      .depth      (depth),
      .stack_ovf  (stack_ovf),
      .stack_unf  (stack_unf)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance past the next rising edge, then let inputs settle away from it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; op = 4'h1;
      #1;
      n_checks++;
      if (ctrl !== V_RESET) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, V_RESET);
      end
      n_checks++;
      if ({halted, cnt_zero} !== 2'b01) begin
         n_fail++; $display("FAIL reset_status: got %b expected 01", {halted, cnt_zero});
      end
      tick();
      reset_n = 1'b1; op = 4'h0;
      #1;
      n_checks++;
      if ({depth, cnt_zero, halted, stack_ovf, stack_unf} !== 7'b0001000) begin
         n_fail++;
         $display("FAIL post_reset_state: got %b expected 0001000",
                  {depth, cnt_zero, halted, stack_ovf, stack_unf});
      end
      n_checks++;
      if (ctrl !== V_CONT) begin
         n_fail++; $display("FAIL post_reset_cont: got %b expected %b", ctrl, V_CONT);
      end
   endtask

   task automatic test_cond_branch();
      op = 4'h2; cond = 1'b1; cond_pol = 1'b1;
      #1;
      n_checks++;
      if (ctrl !== V_JMP) begin
         n_fail++; $display("FAIL cjmp_taken: got %b expected %b", ctrl, V_JMP);
      end
      cond_pol = 1'b0;
      #1;
      n_checks++;
      if (ctrl !== V_CONT) begin
         n_fail++; $display("FAIL cjmp_not_taken: got %b expected %b", ctrl, V_CONT);
      end
      cond = 1'b0;
      #1;
      n_checks++;
      if (ctrl !== V_JMP) begin
         n_fail++; $display("FAIL cjmp_neg_pol: got %b expected %b", ctrl, V_JMP);
      end
      tick();
   endtask

   task automatic test_subroutine();
      op = 4'h3;
      #1;
      n_checks++;
      if (ctrl !== V_JSR) begin
         n_fail++; $display("FAIL jsr_ctrl: got %b expected %b", ctrl, V_JSR);
      end
      tick();
      n_checks++;
      if (depth !== 3'd1) begin
         n_fail++; $display("FAIL jsr_depth: got %0d expected 1", depth);
      end
      op = 4'h5;
      #1;
      n_checks++;
      if (ctrl !== V_RTS) begin
         n_fail++; $display("FAIL rts_ctrl: got %b expected %b", ctrl, V_RTS);
      end
      tick();
      n_checks++;
      if (depth !== 3'd0 || stack_unf !== 1'b0) begin
         n_fail++; $display("FAIL rts_depth: got %0d/%b expected 0/0", depth, stack_unf);
      end
      // Underflowing pop together with clr_flags: the set must win.
      clr_flags = 1'b1;
      #1;
      n_checks++;
      if (ctrl !== V_RTS_UNF) begin
         n_fail++; $display("FAIL rts_unf_ctrl: got %b expected %b", ctrl, V_RTS_UNF);
      end
      tick();
      n_checks++;
      if (stack_unf !== 1'b1 || depth !== 3'd0) begin
         n_fail++; $display("FAIL rts_unf_flag: got %b/%0d expected 1/0", stack_unf, depth);
      end
      op = 4'h0;
      tick();
      clr_flags = 1'b0;
      n_checks++;
      if (stack_unf !== 1'b0) begin
         n_fail++; $display("FAIL unf_clear: got %b expected 0", stack_unf);
      end
   endtask

   task automatic test_repeat_loop();
      logic [6:0] exp_ctrl;
      op = 4'h9; cnt_in = 8'd3;
      #1;
      n_checks++;
      if (ctrl !== V_CONT) begin
         n_fail++; $display("FAIL ldct_ctrl: got %b expected %b", ctrl, V_CONT);
      end
      tick();
      n_checks++;
      if (cnt_zero !== 1'b0) begin
         n_fail++; $display("FAIL ldct_cnt_zero: got %b expected 0", cnt_zero);
      end
      op = 4'hA;
      for (int i = 0; i < 4; i++) begin
         exp_ctrl = (i < 3) ? V_JAR : V_CONT;
         #1;
         n_checks++;
         if (ctrl !== exp_ctrl || cnt_zero !== (i == 3)) begin
            n_fail++;
            $display("FAIL rpct_%0d: got %b/%b expected %b/%b", i, ctrl, cnt_zero,
                     exp_ctrl, (i == 3));
         end
         tick();
      end
      n_checks++;
      if (cnt_zero !== 1'b1) begin
         n_fail++; $display("FAIL rpct_stays_zero: got %b expected 1", cnt_zero);
      end
   endtask

   task automatic test_overflow();
      op = 4'hC;
      for (int i = 1; i <= 4; i++) begin
         #1;
         n_checks++;
         if (ctrl !== V_PUSH) begin
            n_fail++; $display("FAIL push_%0d_ctrl: got %b expected %b", i, ctrl, V_PUSH);
         end
         tick();
         n_checks++;
         if (depth !== 3'(i)) begin
            n_fail++; $display("FAIL push_%0d_depth: got %0d expected %0d", i, depth, i);
         end
      end
      #1;
      n_checks++;
      if (ctrl !== V_PUSH_OVF) begin
         n_fail++; $display("FAIL push_ovf_ctrl: got %b expected %b", ctrl, V_PUSH_OVF);
      end
      tick();
      n_checks++;
      if (stack_ovf !== 1'b1 || depth !== 3'd4) begin
         n_fail++; $display("FAIL push_ovf_flag: got %b/%0d expected 1/4", stack_ovf, depth);
      end
      op = 4'h0; clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      n_checks++;
      if (stack_ovf !== 1'b0) begin
         n_fail++; $display("FAIL ovf_clear: got %b expected 0", stack_ovf);
      end
   endtask

   task automatic test_decode_misc();
      // LOOP with failing test branches to stack top without popping.
      op = 4'hB; cond = 1'b0; cond_pol = 1'b1;
      #1;
      n_checks++;
      if (ctrl !== V_LOOPB) begin
         n_fail++; $display("FAIL loop_branch: got %b expected %b", ctrl, V_LOOPB);
      end
      tick();
      n_checks++;
      if (depth !== 3'd4) begin
         n_fail++; $display("FAIL loop_branch_depth: got %0d expected 4", depth);
      end
      cond = 1'b1;
      #1;
      n_checks++;
      if (ctrl !== V_POP) begin
         n_fail++; $display("FAIL loop_exit: got %b expected %b", ctrl, V_POP);
      end
      tick();
      n_checks++;
      if (depth !== 3'd3) begin
         n_fail++; $display("FAIL loop_exit_depth: got %0d expected 3", depth);
      end
      op = 4'h7;
      #1;
      n_checks++;
      if (ctrl !== V_LDAR) begin
         n_fail++; $display("FAIL ldar: got %b expected %b", ctrl, V_LDAR);
      end
      op = 4'hE;
      #1;
      n_checks++;
      if (ctrl !== V_ZERO) begin
         n_fail++; $display("FAIL zero_op: got %b expected %b", ctrl, V_ZERO);
      end
      op = 4'hF;
      #1;
      n_checks++;
      if (ctrl !== V_CONT) begin
         n_fail++; $display("FAIL reserved_op: got %b expected %b", ctrl, V_CONT);
      end
      tick();
   endtask

   task automatic test_hold_halt();
      hold = 1'b1; op = 4'h3;
      #1;
      n_checks++;
      if (ctrl !== V_STALL) begin
         n_fail++; $display("FAIL hold_ctrl: got %b expected %b", ctrl, V_STALL);
      end
      tick();
      n_checks++;
      if (depth !== 3'd3) begin
         n_fail++; $display("FAIL hold_depth: got %0d expected 3", depth);
      end
      hold = 1'b0; op = 4'hD;
      #1;
      n_checks++;
      if (ctrl !== V_CONT || halted !== 1'b0) begin
         n_fail++; $display("FAIL halt_issue: got %b/%b expected %b/0", ctrl, halted, V_CONT);
      end
      tick();
      op = 4'h3;
      n_checks++;
      if (halted !== 1'b1 || ctrl !== V_STALL) begin
         n_fail++; $display("FAIL halted_state: got %b/%b expected 1/%b", halted, ctrl, V_STALL);
      end
      tick();
      n_checks++;
      if (halted !== 1'b1 || depth !== 3'd3) begin
         n_fail++; $display("FAIL halted_frozen: got %b/%0d expected 1/3", halted, depth);
      end
      start = 1'b1;
      #1;
      n_checks++;
      if (ctrl !== V_STALL) begin
         n_fail++; $display("FAIL halt_start_ctrl: got %b expected %b", ctrl, V_STALL);
      end
      tick();
      start = 1'b0; op = 4'h0;
      #1;
      n_checks++;
      if (halted !== 1'b0 || ctrl !== V_CONT) begin
         n_fail++; $display("FAIL halt_exit: got %b/%b expected 0/%b", halted, ctrl, V_CONT);
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      reset_n = 1'b0; op = 4'h0; cond = 1'b0; cond_pol = 1'b1; cnt_in = 8'd0;
      hold = 1'b0; start = 1'b0; clr_flags = 1'b0;
      #2;
      test_reset();
      test_cond_branch();
      test_subroutine();
      test_repeat_loop();
      test_overflow();
      test_decode_misc();
      test_hold_halt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

endmodule
